// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART controller blocks.
// The GAP arbiter state is compiled in only when UART_ARB_GAP_EN is defined.
package uart_ctrl_pkg;

    localparam int unsigned UART_BYTE_W       = 8;
    localparam int unsigned GAP_TICKS_DEFAULT = 16;
    localparam int unsigned GAP_CNT_W         = 8;

`ifdef UART_ARB_GAP_EN
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_ISSUE,
        ARB_WAIT_DONE,
        ARB_GAP
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_ISSUE,
        ARB_WAIT_DONE
    } arb_state_e;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_ptr, wrapping modulo N.
// Shared between the TX arbiter and the RX-side dispatcher.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    logic [PTR_W-1:0] pos;

    // Explicit modulo keeps the rotation correct when N is not a power of two.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = PTR_W'((32'(last_ptr) + k) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Define UART_ARB_GAP_EN to insert GAP_TICKS idle s_tick pulses between packets.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned GAP_TICKS = GAP_TICKS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           s_tick,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           arb_busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       last_ptr_q, last_ptr_d;
    logic                   last_q, last_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;

    logic [NUM_REQ-1:0]     rr_gnt;
    logic [PTR_W-1:0]       rr_idx;
    logic [UART_BYTE_W-1:0] sel_data;
    logic                   sel_last;
    logic                   sel_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req      (req_valid),
        .last_ptr (last_ptr_q),
        .gnt      (rr_gnt),
        .idx      (rr_idx)
    );

    // Byte and last flag of the granted requester.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
                sel_last = req_last[i];
            end
        end
    end

    assign sel_valid = req_valid[gidx_q];

`ifdef UART_ARB_GAP_EN
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`else
    logic unused_gap;
    assign unused_gap = s_tick ^ (GAP_TICKS == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_ptr_q <= PTR_W'(NUM_REQ - 1);
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_ptr_q <= last_ptr_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Next-state logic; tx_start is set on accept so it is high for the ISSUE cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_ptr_d = last_ptr_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifdef UART_ARB_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_gnt;
                    gidx_d  = rr_idx;
                    state_d = ARB_SEND;
                end
            end
            ARB_SEND: begin
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    last_d     = sel_last;
                    tx_start_d = 1'b1;
                    state_d    = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                if (tx_done) begin
                    if (!last_q) begin
                        state_d = ARB_SEND;
                    end else begin
                        last_ptr_d = gidx_q;
                        grant_d    = '0;
`ifdef UART_ARB_GAP_EN
                        gap_cnt_d  = '0;
                        state_d    = ARB_GAP;
`else
                        state_d    = ARB_IDLE;
`endif
                    end
                end
            end
`ifdef UART_ARB_GAP_EN
            ARB_GAP: begin
                if (s_tick) begin
                    if (gap_cnt_q == GAP_CNT_W'(GAP_TICKS - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = ARB_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ARB_SEND) ? (grant_q & req_valid) : '0;
    assign grant     = grant_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign arb_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packets
// compared every cycle against a packet-level behavioural model.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int GAPT = 16;
`ifdef UART_ARB_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           s_tick;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [N-1:0]   grant;
    logic           arb_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_TICKS(GAPT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .s_tick    (s_tick),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant     (grant),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Requester-side packet queues and stimulus controls
    logic [7:0] q_byte   [N][$];
    bit         q_last   [N][$];
    logic [7:0] exp_sent [N][$];
    logic [7:0] got_sent [N][$];
    logic [7:0] tx_log   [$];
    int         grant_log[$];
    int         pct      [N];
    bit         hold_low [N];
    logic [N-1:0] acc;
    bit  start_seen, env_wait, env_hold, stray_en;
    int  done_cnt, n_real_done;

    // Behavioural model: who owns the line and what the packet is doing
    int         m_owner;
    bit         m_await, m_start, m_fly, m_lastb, m_armed;
    int         m_lptr, m_gap;
    logic [7:0] m_data;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        int pick;
        cyc++;
        if (m_armed) begin
            e_ready = '0;
            if (m_owner >= 0 && m_await) e_ready[m_owner] = req_valid[m_owner];
            chk("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("arb_busy", int'(arb_busy), int'(m_owner >= 0 || m_gap > 0));
            chk("tx_start", int'(tx_start), int'(m_start));
            chk("tx_data", int'(tx_data), int'(m_data));
            chk("req_ready", int'(req_ready), int'(e_ready));
            if (tx_start && m_owner >= 0) begin
                tx_log.push_back(tx_data);
                got_sent[m_owner].push_back(tx_data);
            end
        end
        acc        = req_ready & req_valid;
        start_seen = tx_start;
        if (rst) begin
            m_owner = -1; m_await = 0; m_start = 0; m_fly = 0; m_lastb = 0;
            m_lptr  = N - 1; m_gap = 0; m_data = 8'h00; m_armed = 1;
        end else if (m_armed) begin
            if (m_owner < 0) begin
                if (m_gap > 0) begin
                    if (s_tick) m_gap--;
                end else if (|req_valid) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (pick < 0 && req_valid[(m_lptr + k) % N]) pick = (m_lptr + k) % N;
                    end
                    m_owner = pick;
                    m_await = 1;
                    grant_log.push_back(pick);
                end
            end else if (m_await) begin
                if (req_valid[m_owner]) begin
                    m_data  = req_data[8*m_owner +: 8];
                    m_lastb = req_last[m_owner];
                    m_await = 0;
                    m_start = 1;
                end
            end else if (m_start) begin
                m_start = 0;
                m_fly   = 1;
            end else if (m_fly && tx_done) begin
                m_fly = 0;
                if (m_lastb) begin
                    m_lptr  = m_owner;
                    m_owner = -1;
                    m_gap   = GAP_ON ? GAPT : 0;
                end else begin
                    m_await = 1;
                end
            end
        end
    end

    // One clock of stimulus: retire accepted bytes, present new ones, emulate the transmitter.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && q_byte[i].size() > 0) begin
                void'(q_byte[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (q_byte[i].size() > 0) && !hold_low[i] &&
                           ($urandom_range(99) < pct[i]);
            req_data[8*i +: 8] = (q_byte[i].size() > 0) ? q_byte[i][0] : 8'($urandom);
            req_last[i] = (q_last[i].size() > 0) ? q_last[i][0] : 1'($urandom);
        end
        tx_done = 1'b0;
        if (start_seen && !rst) begin
            env_wait = 1'b1;
            done_cnt = $urandom_range(1, 6);
        end
        if (env_wait) begin
            if (!env_hold) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done  = 1'b1;
                    env_wait = 1'b0;
                    n_real_done++;
                end
            end
        end else if (stray_en && $urandom_range(15) == 0) begin
            tx_done = 1'b1;
        end
        s_tick = ($urandom_range(3) == 0);
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            q_byte[i].delete();
            q_last[i].delete();
            hold_low[i] = 1'b0;
            pct[i]      = 100;
        end
        env_wait = 1'b0; env_hold = 1'b0; stray_en = 1'b0; done_cnt = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        clear_env();
        step();
        rst = 1'b0;
    endtask

    task automatic push_pkt(input int r, input logic [7:0] b [$]);
        foreach (b[k]) begin
            q_byte[r].push_back(b[k]);
            q_last[r].push_back(k == b.size() - 1);
        end
    endtask

    function automatic bit idle_now();
        for (int i = 0; i < N; i++) if (q_byte[i].size() > 0) return 1'b0;
        return (m_owner < 0) && (m_gap == 0) && !env_wait;
    endfunction

    task automatic run_until_idle(input int maxc);
        int c;
        c = 0;
        while (!idle_now() && c < maxc) begin
            step();
            c++;
        end
        chk("idle_timeout", int'(idle_now()), 1);
        repeat (3) step();
    endtask

    initial begin
        logic [7:0] pk [$];
        int base, c;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        s_tick = 1'b0; tx_done = 1'b0;
        acc = '0; start_seen = 0; n_real_done = 0; done_cnt = 0;
        m_armed = 0; m_owner = -1; m_gap = 0;
        clear_env();
        step();
        step();
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(arb_busy), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // Single packet from requester 0: first-byte latency
        pk = '{8'hA5, 8'h3C};
        push_pkt(0, pk);
        tx_log.delete();
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        chk("single_grant_c1", int'(grant), 1);
        chk("single_ready_c1", int'(req_ready), 1);
        step();
        @(negedge clk);
        chk("single_start_c2", int'(tx_start), 1);
        chk("single_data_c2", int'(tx_data), 8'hA5);
        run_until_idle(200);
        chk("single_bytes", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("single_byte1", int'(tx_log[1]), 8'h3C);

        // Contention: requesters 1 and 3 valid together after reset
        do_reset();
        tx_log.delete(); grant_log.delete();
        pk = '{8'h11, 8'h12, 8'h13}; push_pkt(1, pk);
        pk = '{8'h31, 8'h32, 8'h33}; push_pkt(3, pk);
        run_until_idle(400);
        chk("cont_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("cont_first", grant_log[0], 1);
            chk("cont_second", grant_log[1], 3);
        end
        chk("cont_nbytes", tx_log.size(), 6);
        if (tx_log.size() == 6) begin
            pk = '{8'h11, 8'h12, 8'h13, 8'h31, 8'h32, 8'h33};
            foreach (pk[k]) chk("cont_byte", int'(tx_log[k]), int'(pk[k]));
        end

        // Fairness: all requesters continuously valid with 1-byte packets
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                pk = '{8'(8'h80 + 16*r + i)};
                push_pkt(i, pk);
            end
        run_until_idle(600);
        chk("fair_ngrants", grant_log.size(), 2 * N);
        if (grant_log.size() == 2 * N)
            foreach (grant_log[k]) chk("fair_order", grant_log[k], k % N);

        // Stall: requester 0 drops valid between bytes while requester 2 waits
        do_reset();
        grant_log.delete();
        pk = '{8'h40, 8'h41}; push_pkt(0, pk);
        pk = '{8'h50};        push_pkt(2, pk);
        c = 0;
        while (q_byte[0].size() != 1 && c < 50) begin step(); c++; end
        hold_low[0] = 1'b1;
        req_valid[0] = 1'b0;
        base = n_real_done;
        c = 0;
        while (n_real_done == base && c < 50) begin step(); c++; end
        chk("stall_first_done", int'(n_real_done != base), 1);
        step();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("stall_grant", int'(grant), 1);
            chk("stall_ready2", int'(req_ready[2]), 0);
            chk("stall_tx_start", int'(tx_start), 0);
            step();
        end
        hold_low[0] = 1'b0;
        run_until_idle(300);
        chk("stall_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("stall_second", grant_log[1], 2);

        // Reset while waiting for tx_done
        do_reset();
        env_hold = 1'b1;
        pk = '{8'h60, 8'h61}; push_pkt(1, pk);
        c = 0;
        while (c < 20) begin
            step();
            @(negedge clk);
            if (tx_start) break;
            c++;
        end
        chk("midrst_started", int'(tx_start), 1);
        step();
        rst = 1'b1;
        clear_env();
        @(negedge clk);
        chk("midrst_busy_before", int'(arb_busy), 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_busy", int'(arb_busy), 0);
        chk("midrst_tx_start", int'(tx_start), 0);
        chk("midrst_tx_data", int'(tx_data), 0);

        // Randomized packets with stalls and stray tx_done pulses
        do_reset();
        stray_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_sent[i].delete();
            got_sent[i].delete();
            pct[i] = $urandom_range(30, 100);
            for (int p = 0; p < int'($urandom_range(3, 8)); p++) begin
                pk.delete();
                for (int b = 0; b < int'($urandom_range(1, 4)); b++) pk.push_back(8'($urandom));
                push_pkt(i, pk);
                foreach (pk[k]) exp_sent[i].push_back(pk[k]);
            end
        end
        run_until_idle(20000);
        for (int i = 0; i < N; i++) begin
            chk("rand_count", got_sent[i].size(), exp_sent[i].size());
            if (got_sent[i].size() == exp_sent[i].size())
                foreach (exp_sent[i][k]) chk("rand_byte", int'(got_sent[i][k]), int'(exp_sent[i][k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
